fifo_pkt_reader: RTL and testbench



---
 rtl/fifo_pkt_pkg.sv | 21 ++
 rtl/fifo_pkt_reader_if.sv | 50 +++++
 rtl/fifo_pkt_reader.sv | 125 ++++++++++++
 tb/tb_fifo_pkt_reader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the FIFO packet reader.
// Holds the FSM state encoding, the header field layout (tag above, length below
// a LEN_W split point) and the default length limit.
package fifo_pkt_pkg;

    typedef enum logic [1:0] {
        StHdr  = 2'd0,
        StPay  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Header word: bits [HdrW-1:LEN_W] carry the tag, bits [LEN_W-1:0] the payload length.
    localparam int unsigned HdrW      = 32;
    localparam int unsigned DefLenW   = 16;
    localparam int unsigned DefMaxLen = 256;

    function automatic int unsigned tag_w(input int unsigned len_w);
        return HdrW - len_w;
    endfunction

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// Method-style handshake bundle for the FIFO packet reader.
//   Upstream FIFO side : in_first__RDY, in_first, in_deq__RDY, in_deq__ENA
//   Result side        : result__RDY, result__ENA, result_tag/len/sum/err
// Modports: slave = the reader itself, master = the environment around it
// (upstream FIFO plus downstream result consumer).
interface fifo_pkt_reader_if
    import fifo_pkt_pkg::*;
#(
    parameter int unsigned LEN_W = DefLenW
);

    logic                    in_first__RDY;
    logic [HdrW-1:0]         in_first;
    logic                    in_deq__RDY;
    logic                    in_deq__ENA;

    logic                    result__RDY;
    logic                    result__ENA;
    logic [HdrW-LEN_W-1:0]   result_tag;
    logic [LEN_W-1:0]        result_len;
    logic [31:0]             result_sum;
    logic                    result_err;

    modport slave (
        input  in_first__RDY,
        input  in_first,
        input  in_deq__RDY,
        output in_deq__ENA,
        output result__RDY,
        input  result__ENA,
        output result_tag,
        output result_len,
        output result_sum,
        output result_err
    );

    modport master (
        output in_first__RDY,
        output in_first,
        output in_deq__RDY,
        input  in_deq__ENA,
        input  result__RDY,
        output result__ENA,
        input  result_tag,
        input  result_len,
        input  result_sum,
        input  result_err
    );

endinterface

// File: rtl/fifo_pkt_reader.sv
// Drains framed packets (header word, then len payload words) from an upstream
// FIFO and presents {tag, len, mod-2^32 payload sum} on a result method port.
// Ports:
//   CLK     clock
//   nRST    synchronous active-low reset
//   bus_io  fifo_pkt_reader_if.slave (upstream deq handshake + result handshake)
// Build option: FIFO_PKT_READER_LENCHK_EN flags headers with len > MAX_LEN via
// result_err; such payloads are drained but not summed. Without it result_err
// is tied low and MAX_LEN is unused.
module fifo_pkt_reader
    import fifo_pkt_pkg::*;
#(
    parameter int unsigned LEN_W   = DefLenW,
    parameter int unsigned MAX_LEN = DefMaxLen
) (
    input logic               CLK,
    input logic               nRST,
    fifo_pkt_reader_if.slave  bus_io
);

    localparam int unsigned TagW = tag_w(LEN_W);

    state_e            state_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  len_q;
    logic [TagW-1:0]   tag_q;
    logic [31:0]       sum_q;
    logic              rdy_q;

    logic              deq_ena;
    logic [LEN_W-1:0]  hdr_len;
    logic [TagW-1:0]   hdr_tag;

    assign hdr_len = bus_io.in_first[LEN_W-1:0];
    assign hdr_tag = bus_io.in_first[HdrW-1:LEN_W];

    // Pop is combinational so a word can be taken every cycle; DONE never pops,
    // which guarantees the next header is taken no earlier than a cycle after result__ENA.
    assign deq_ena = nRST & bus_io.in_first__RDY & bus_io.in_deq__RDY &
                     ((state_q == StHdr) | (state_q == StPay));

`ifdef FIFO_PKT_READER_LENCHK_EN
    logic err_q;
    logic oversize;

    assign oversize = (32'(hdr_len) > MAX_LEN);
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= StHdr;
            rem_q   <= '0;
            len_q   <= '0;
            tag_q   <= '0;
            sum_q   <= '0;
            rdy_q   <= 1'b0;
`ifdef FIFO_PKT_READER_LENCHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StHdr: begin
                    if (deq_ena) begin
                        tag_q <= hdr_tag;
                        len_q <= hdr_len;
                        sum_q <= '0;
`ifdef FIFO_PKT_READER_LENCHK_EN
                        err_q <= oversize;
`endif
                        if (hdr_len == '0) begin
                            state_q <= StDone;
                            rdy_q   <= 1'b1;
                        end else begin
                            rem_q   <= hdr_len;
                            state_q <= StPay;
                        end
                    end
                end
                StPay: begin
                    if (deq_ena) begin
`ifdef FIFO_PKT_READER_LENCHK_EN
                        // Oversize packets are drained but their payload is discarded.
                        if (!err_q) begin
                            sum_q <= sum_q + bus_io.in_first;
                        end
`else
                        sum_q <= sum_q + bus_io.in_first;
`endif
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= StDone;
                            rdy_q   <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (bus_io.result__ENA) begin
                        state_q <= StHdr;
                        rdy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StHdr;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.in_deq__ENA = deq_ena;
    assign bus_io.result__RDY = rdy_q;
    assign bus_io.result_tag  = tag_q;
    assign bus_io.result_len  = len_q;
    assign bus_io.result_sum  = sum_q;

`ifdef FIFO_PKT_READER_LENCHK_EN
    assign bus_io.result_err  = err_q;
`else
    logic unused_max_len;

    assign unused_max_len    = ^32'(MAX_LEN);
    assign bus_io.result_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Self-checking bench for fifo_pkt_reader: drives framed packets from a simple
// upstream model, pushes the expected {tag, len, sum, err} per packet into a
// scoreboard and pops/compares when the reader presents a result.
module tb_fifo_pkt_reader;
    import fifo_pkt_pkg::*;

    localparam int unsigned LenW   = 16;
    localparam int unsigned MaxLen = 4;

    typedef struct packed {
        logic [15:0] tag;
        logic [15:0] len;
        logic [31:0] sum;
        logic        err;
    } exp_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    always #5 CLK = ~CLK;

    fifo_pkt_reader_if #(.LEN_W(LenW)) bus ();

    fifo_pkt_reader #(
        .LEN_W   (LenW),
        .MAX_LEN (MaxLen)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus_io (bus.slave)
    );

    exp_t        sb_q[$];
    logic [31:0] pay[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one word, optionally after a stall, and wait until it is popped.
    task automatic feed(input logic [31:0] w, input int stall, output int waited);
        waited = 0;
        if (stall > 0) begin
            bus.in_first__RDY = 1'b0;
            for (int i = 0; i < stall; i++) begin
                step();
                check_val("stall_deq", 32'(bus.in_deq__ENA), 32'd0);
                check_val("stall_rdy", 32'(bus.result__RDY), 32'd0);
            end
        end
        bus.in_first      = w;
        bus.in_first__RDY = 1'b1;
        #1;
        while (!bus.in_deq__ENA && waited < 50) begin
            step();
            waited++;
        end
        if (!bus.in_deq__ENA) check_val("feed_timeout", 32'(bus.in_deq__ENA), 32'd1);
        step();
    endtask

    // Send header plus the words in pay[]; stall_n idle cycles before word stall_idx
    // (0 = header). Expected result comes from an independent model of the packet.
    task automatic send_pkt(input logic [15:0] tag, input int stall_idx, input int stall_n,
                            output int gaps);
        exp_t e;
        int   w;
        e.tag = tag;
        e.len = 16'(pay.size());
        e.sum = 32'd0;
        e.err = 1'b0;
        gaps  = 0;
        feed({tag, e.len}, (stall_idx == 0) ? stall_n : 0, w);
        gaps += w;
        for (int i = 0; i < pay.size(); i++) begin
            feed(pay[i], (stall_idx == i + 1) ? stall_n : 0, w);
            gaps  += w;
            e.sum += pay[i];
        end
`ifdef FIFO_PKT_READER_LENCHK_EN
        if (32'(e.len) > MaxLen) begin
            e.err = 1'b1;
            e.sum = 32'd0;
        end
`endif
        sb_q.push_back(e);
    endtask

    // Wait for a result, compare it for hold+1 cycles, then accept it with result__ENA.
    task automatic take_result(input int hold, input bit next_ready);
        exp_t e;
        int   n = 0;
        while (!bus.result__RDY && n < 200) begin
            step();
            n++;
        end
        if (!bus.result__RDY) begin
            check_val("result_timeout", 32'(bus.result__RDY), 32'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            check_val("res_rdy", 32'(bus.result__RDY), 32'd1);
            check_val("res_tag", 32'(bus.result_tag), 32'(e.tag));
            check_val("res_len", 32'(bus.result_len), 32'(e.len));
            check_val("res_sum", bus.result_sum, e.sum);
            check_val("res_err", 32'(bus.result_err), 32'(e.err));
            check_val("done_no_deq", 32'(bus.in_deq__ENA), 32'd0);
            if (i < hold) step();
        end
        bus.result__ENA = 1'b1;
        step();
        bus.result__ENA = 1'b0;
        check_val("rdy_after_ena", 32'(bus.result__RDY), 32'd0);
        if (next_ready) check_val("hdr_after_ena", 32'(bus.in_deq__ENA), 32'd1);
        else bus.in_first__RDY = 1'b0;
    endtask

    initial begin
        int gaps;
        bus.in_first__RDY = 1'b1;
        bus.in_first      = 32'h1234_5678;
        bus.in_deq__RDY   = 1'b1;
        bus.result__ENA   = 1'b0;

        // Reset: no pops while nRST is low, outputs cleared.
        #1;
        check_val("rst_deq", 32'(bus.in_deq__ENA), 32'd0);
        repeat (3) step();
        check_val("rst_rdy", 32'(bus.result__RDY), 32'd0);
        check_val("rst_sum", bus.result_sum, 32'd0);
        check_val("rst_len", 32'(bus.result_len), 32'd0);
        check_val("rst_tag", 32'(bus.result_tag), 32'd0);
        check_val("rst_err", 32'(bus.result_err), 32'd0);
        bus.in_first__RDY = 1'b0;
        nRST = 1'b1;
        step();

        // Back-to-back 3-word packet: 4 consecutive pops, result right after the last.
        pay = '{32'd1, 32'd2, 32'd3};
        send_pkt(16'h0005, 0, 0, gaps);
        check_val("b2b_gaps", 32'(gaps), 32'd0);
        check_val("b2b_latency", 32'(bus.result__RDY), 32'd1);
        take_result(0, 1'b0);

        // Zero-length packet: DONE right after the header, no pops while upstream ready.
        pay = {};
        send_pkt(16'h00AA, 0, 0, gaps);
        check_val("len0_latency", 32'(bus.result__RDY), 32'd1);
        take_result(2, 1'b0);

        // Carry wraps; 3-cycle upstream stall between the payload words.
        pay = '{32'hFFFF_FFFF, 32'h0000_0002};
        send_pkt(16'h0011, 2, 3, gaps);
        // Hold result 10 cycles with the next header already waiting upstream.
        bus.in_first = {16'h0007, 16'd2};
        take_result(10, 1'b1);

        pay = '{32'd10, 32'd20};
        send_pkt(16'h0007, 0, 0, gaps);
        take_result(0, 1'b0);

        // Reset after 1 of 4 payload words abandons the packet.
        feed({16'h0009, 16'd4}, 0, gaps);
        feed(32'h0000_0011, 0, gaps);
        nRST = 1'b0;
        #1;
        check_val("midrst_deq", 32'(bus.in_deq__ENA), 32'd0);
        step();
        check_val("midrst_rdy", 32'(bus.result__RDY), 32'd0);
        check_val("midrst_sum", bus.result_sum, 32'd0);
        check_val("midrst_len", 32'(bus.result_len), 32'd0);
        nRST = 1'b1;
        pay = '{32'h0000_0007};
        send_pkt(16'h0001, 0, 0, gaps);
        take_result(0, 1'b0);

        // Length above MaxLen (flagged only with the length check built in).
        pay = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        send_pkt(16'h0003, 0, 0, gaps);
        take_result(0, 1'b0);
        pay = '{32'd9};
        send_pkt(16'h0004, 0, 0, gaps);
        take_result(0, 1'b0);

        // Random packets with random stalls and hold times.
        for (int p = 0; p < 8; p++) begin
            int len;
            len = $urandom_range(0, 6);
            pay = {};
            for (int i = 0; i < len; i++) pay.push_back($urandom);
            send_pkt(16'($urandom), $urandom_range(0, len), $urandom_range(0, 3), gaps);
            take_result($urandom_range(0, 2), 1'b0);
        end

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
